alu_seq_top: RTL and testbench

Board-level ALU front end, successor to the three-button operand loader. Switch data is loaded through a debounced, edge-detected single-button sequence: A, then B, then opcode. The opcode is executed in a registered ALU stage that produces result and N/Z/C/V flags. An accumulate mode re-runs the last operation with the previous result as A. The block sits between board I/O (switches, buttons, LEDs) and the display logic.

---
 rtl/alu_seq_top.sv | 176 +++++++++++++++++
 tb/tb_alu_seq_top.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_top.sv
// Board-level ALU front end: debounced single-button A/B/opcode loader feeding a
// registered ALU stage with N/Z/C/V/ERR flags and an accumulate mode.
module alu_seq_top #(
  parameter int OPERAND_SIZE    = 8,
  parameter int OP_CODE_SIZE    = 6,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                    CLK100MHZ,
  input  logic                    CPU_RESETN,
  input  logic [OPERAND_SIZE-1:0] sw,
  input  logic                    btnC,
  input  logic                    btnL,
  input  logic                    btnR,
  output logic [OPERAND_SIZE-1:0] o_result,
  output logic [4:0]              o_flags,
  output logic [2:0]              o_state,
  output logic                    o_valid
);

  localparam int W   = OPERAND_SIZE;
  localparam int MSB = OPERAND_SIZE - 1;
  localparam int CW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [W-1:0]  SH_LIM   = W'(OPERAND_SIZE);

  localparam logic [OP_CODE_SIZE-1:0] OP_ADD = OP_CODE_SIZE'(6'b100000);
  localparam logic [OP_CODE_SIZE-1:0] OP_SUB = OP_CODE_SIZE'(6'b100010);
  localparam logic [OP_CODE_SIZE-1:0] OP_AND = OP_CODE_SIZE'(6'b100100);
  localparam logic [OP_CODE_SIZE-1:0] OP_OR  = OP_CODE_SIZE'(6'b100101);
  localparam logic [OP_CODE_SIZE-1:0] OP_XOR = OP_CODE_SIZE'(6'b100110);
  localparam logic [OP_CODE_SIZE-1:0] OP_NOR = OP_CODE_SIZE'(6'b100111);
  localparam logic [OP_CODE_SIZE-1:0] OP_SRA = OP_CODE_SIZE'(6'b000011);
  localparam logic [OP_CODE_SIZE-1:0] OP_SRL = OP_CODE_SIZE'(6'b000010);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  // Button path, bit order {R, L, C}
  logic [2:0]    raw, sync1, sync2, deb, deb_q, ev;
  logic [CW-1:0] cnt [3];

  assign raw = {btnR, btnL, btnC};

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      cnt   <= '{default: '0};
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == CNT_LAST) begin
            deb[i] <= ~deb[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign ev = deb & ~deb_q;

  state_t                  state, state_n;
  logic [W-1:0]            a, a_n, b, b_n, result, result_n;
  logic [OP_CODE_SIZE-1:0] op, op_n;
  logic [4:0]              flags, flags_n;
  logic                    valid_n;

  logic [W-1:0] alu_r;
  logic [W:0]   sum;
  logic         alu_c, alu_v, alu_err;

  always_comb begin
    alu_r   = '0;
    sum     = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op)
      OP_ADD: begin
        sum   = {1'b0, a} + {1'b0, b};
        alu_r = sum[W-1:0];
        alu_c = sum[W];
        alu_v = (a[MSB] == b[MSB]) && (alu_r[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_r = a - b;
        alu_c = (a < b);
        alu_v = (a[MSB] != b[MSB]) && (alu_r[MSB] != a[MSB]);
      end
      OP_AND: alu_r = a & b;
      OP_OR:  alu_r = a | b;
      OP_XOR: alu_r = a ^ b;
      OP_NOR: alu_r = ~(a | b);
      OP_SRA: alu_r = (b >= SH_LIM) ? {W{a[MSB]}} : W'($signed(a) >>> b);
      OP_SRL: alu_r = (b >= SH_LIM) ? '0 : (a >> b);
      default: alu_err = 1'b1;
    endcase
  end

  // evL > evR > evC; a lower-priority event in the same cycle is dropped even
  // when the higher one has no effect in the current state.
  always_comb begin
    state_n  = state;
    a_n      = a;
    b_n      = b;
    op_n     = op;
    result_n = result;
    flags_n  = flags;
    valid_n  = 1'b0;
    if (state == S_EXEC) begin
      state_n  = S_SHOW;
      result_n = alu_r;
      flags_n  = {alu_err, alu_r[MSB], (alu_r == '0), alu_c, alu_v};
      valid_n  = 1'b1;
    end else if (ev[1]) begin
      state_n    = S_A;
      a_n        = '0;
      b_n        = '0;
      op_n       = '0;
      flags_n[4] = 1'b0;
    end else if (ev[2]) begin
      if (state == S_SHOW) begin
        a_n     = result;
        b_n     = sw;
        state_n = S_EXEC;
      end
    end else if (ev[0]) begin
      case (state)
        S_A, S_SHOW: begin a_n = sw; state_n = S_B; end
        S_B:         begin b_n = sw; state_n = S_OP; end
        S_OP:        begin op_n = sw[OP_CODE_SIZE-1:0]; state_n = S_EXEC; end
        default:     state_n = S_A;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state  <= S_A;
      a      <= '0;
      b      <= '0;
      op     <= '0;
      result <= '0;
      flags  <= '0;
      o_valid <= 1'b0;
    end else begin
      state  <= state_n;
      a      <= a_n;
      b      <= b_n;
      op     <= op_n;
      result <= result_n;
      flags  <= flags_n;
      o_valid <= valid_n;
    end
  end

  assign o_result = result;
  assign o_flags  = flags;
  assign o_state  = state;

endmodule

// File: tb/tb_alu_seq_top.sv
// Directed bench for alu_seq_top with a short debounce window; expected values
// are hand-computed per vector.
module tb_alu_seq_top;

  logic       CLK100MHZ;
  logic       CPU_RESETN;
  logic [7:0] sw;
  logic       btnC, btnL, btnR;
  logic [7:0] o_result;
  logic [4:0] o_flags;
  logic [2:0] o_state;
  logic       o_valid;

  int vectors;
  int miscompares;
  int valid_cnt;

  alu_seq_top #(
    .OPERAND_SIZE(8),
    .OP_CODE_SIZE(6),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLK100MHZ(CLK100MHZ),
    .CPU_RESETN(CPU_RESETN),
    .sw(sw),
    .btnC(btnC),
    .btnL(btnL),
    .btnR(btnR),
    .o_result(o_result),
    .o_flags(o_flags),
    .o_state(o_state),
    .o_valid(o_valid)
  );

  initial CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  always @(negedge CLK100MHZ) if (o_valid === 1'b1) valid_cnt++;

  // kind: 0=C 1=L 2=R 3=L+C 4=R+C
  task automatic press(input int unsigned kind, input int unsigned hold);
    @(negedge CLK100MHZ);
    btnC = (kind == 0 || kind == 3 || kind == 4);
    btnL = (kind == 1 || kind == 3);
    btnR = (kind == 2 || kind == 4);
    repeat (hold) @(negedge CLK100MHZ);
    btnC = 1'b0;
    btnL = 1'b0;
    btnR = 1'b0;
    repeat (12) @(negedge CLK100MHZ);
  endtask

  task automatic load_seq(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] vop);
    sw = va;  press(0, 10);
    sw = vb;  press(0, 10);
    sw = vop; press(0, 10);
  endtask

  task automatic test_reset;
    CPU_RESETN = 1'b0;
    sw = '0; btnC = 1'b0; btnL = 1'b0; btnR = 1'b0;
    repeat (3) @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    repeat (2) @(negedge CLK100MHZ);
    vectors += 4;
    if (o_result !== 8'h00) begin miscompares++; $display("FAIL reset_result: got %h expected 00", o_result); end
    if (o_flags !== 5'b00000) begin miscompares++; $display("FAIL reset_flags: got %b expected 00000", o_flags); end
    if (o_state !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", o_state); end
    if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
  endtask

  task automatic test_add;
    int p;
    p = valid_cnt;
    sw = 8'h05; press(0, 10);
    vectors++;
    if (o_state !== 3'd1) begin miscompares++; $display("FAIL add_state_after_a: got %0d expected 1", o_state); end
    sw = 8'h03; press(0, 10);
    vectors++;
    if (o_state !== 3'd2) begin miscompares++; $display("FAIL add_state_after_b: got %0d expected 2", o_state); end
    sw = 8'h20; press(0, 10);
    vectors += 4;
    if (o_result !== 8'h08) begin miscompares++; $display("FAIL add_result: got %h expected 08", o_result); end
    if (o_flags !== 5'b00000) begin miscompares++; $display("FAIL add_flags: got %b expected 00000", o_flags); end
    if (o_state !== 3'd4) begin miscompares++; $display("FAIL add_state_show: got %0d expected 4", o_state); end
    if (valid_cnt - p != 1) begin miscompares++; $display("FAIL add_valid_pulses: got %0d expected 1", valid_cnt - p); end
  endtask

  task automatic test_accumulate;
    logic [7:0] exp_r [2] = '{8'h0A, 8'h0C};
    int p;
    sw = 8'h02;
    for (int i = 0; i < 2; i++) begin
      p = valid_cnt;
      press(2, 10);
      vectors += 3;
      if (o_result !== exp_r[i]) begin miscompares++; $display("FAIL acc_result[%0d]: got %h expected %h", i, o_result, exp_r[i]); end
      if (o_state !== 3'd4) begin miscompares++; $display("FAIL acc_state[%0d]: got %0d expected 4", i, o_state); end
      if (valid_cnt - p != 1) begin miscompares++; $display("FAIL acc_valid_pulses[%0d]: got %0d expected 1", i, valid_cnt - p); end
    end
    // R and C together in S_SHOW: accumulate wins, C is dropped
    sw = 8'h01;
    press(4, 10);
    vectors += 2;
    if (o_result !== 8'h0D) begin miscompares++; $display("FAIL prio_rc_result: got %h expected 0D", o_result); end
    if (o_state !== 3'd4) begin miscompares++; $display("FAIL prio_rc_state: got %0d expected 4", o_state); end
  endtask

  task automatic test_sub_add;
    logic [7:0] va [4] = '{8'h80, 8'h01, 8'hFF, 8'h7F};
    logic [7:0] vb [4] = '{8'h01, 8'h02, 8'h01, 8'h01};
    logic [7:0] vo [4] = '{8'h22, 8'h22, 8'h20, 8'h20};
    logic [7:0] er [4] = '{8'h7F, 8'hFF, 8'h00, 8'h80};
    logic [4:0] ef [4] = '{5'b00001, 5'b01010, 5'b00110, 5'b01001};
    int p;
    for (int i = 0; i < 4; i++) begin
      p = valid_cnt;
      load_seq(va[i], vb[i], vo[i]);
      vectors += 3;
      if (o_result !== er[i]) begin miscompares++; $display("FAIL arith_result[%0d]: got %h expected %h", i, o_result, er[i]); end
      if (o_flags !== ef[i]) begin miscompares++; $display("FAIL arith_flags[%0d]: got %b expected %b", i, o_flags, ef[i]); end
      if (valid_cnt - p != 1) begin miscompares++; $display("FAIL arith_valid[%0d]: got %0d expected 1", i, valid_cnt - p); end
    end
  endtask

  task automatic test_logic;
    logic [7:0] va [4] = '{8'hF0, 8'hF0, 8'hAA, 8'h0F};
    logic [7:0] vb [4] = '{8'h3C, 8'h0F, 8'hAA, 8'h30};
    logic [7:0] vo [4] = '{8'h24, 8'h25, 8'h26, 8'h27};
    logic [7:0] er [4] = '{8'h30, 8'hFF, 8'h00, 8'hC0};
    logic [4:0] ef [4] = '{5'b00000, 5'b01000, 5'b00100, 5'b01000};
    for (int i = 0; i < 4; i++) begin
      load_seq(va[i], vb[i], vo[i]);
      vectors += 2;
      if (o_result !== er[i]) begin miscompares++; $display("FAIL logic_result[%0d]: got %h expected %h", i, o_result, er[i]); end
      if (o_flags !== ef[i]) begin miscompares++; $display("FAIL logic_flags[%0d]: got %b expected %b", i, o_flags, ef[i]); end
    end
  endtask

  task automatic test_shift;
    logic [7:0] vb [5] = '{8'h09, 8'h09, 8'h02, 8'h04, 8'h08};
    logic [7:0] vo [5] = '{8'h03, 8'h02, 8'h03, 8'h02, 8'h02};
    logic [7:0] er [5] = '{8'hFF, 8'h00, 8'hE4, 8'h09, 8'h00};
    logic [4:0] ef [5] = '{5'b01000, 5'b00100, 5'b01000, 5'b00000, 5'b00100};
    for (int i = 0; i < 5; i++) begin
      load_seq(8'h90, vb[i], vo[i]);
      vectors += 2;
      if (o_result !== er[i]) begin miscompares++; $display("FAIL shift_result[%0d]: got %h expected %h", i, o_result, er[i]); end
      if (o_flags !== ef[i]) begin miscompares++; $display("FAIL shift_flags[%0d]: got %b expected %b", i, o_flags, ef[i]); end
    end
  endtask

  task automatic test_invalid;
    load_seq(8'h12, 8'h34, 8'h3F);
    vectors += 2;
    if (o_result !== 8'h00) begin miscompares++; $display("FAIL inv_result: got %h expected 00", o_result); end
    if (o_flags !== 5'b10100) begin miscompares++; $display("FAIL inv_flags: got %b expected 10100", o_flags); end
    press(1, 10);
    vectors += 3;
    if (o_state !== 3'd0) begin miscompares++; $display("FAIL clr_state: got %0d expected 0", o_state); end
    if (o_flags !== 5'b00100) begin miscompares++; $display("FAIL clr_flags: got %b expected 00100", o_flags); end
    if (o_result !== 8'h00) begin miscompares++; $display("FAIL clr_result: got %h expected 00", o_result); end
  endtask

  task automatic test_bounce;
    sw = 8'h11;
    press(0, 3);
    vectors++;
    if (o_state !== 3'd0) begin miscompares++; $display("FAIL glitch_state: got %0d expected 0", o_state); end
    press(0, 30);
    vectors++;
    if (o_state !== 3'd1) begin miscompares++; $display("FAIL hold_state: got %0d expected 1", o_state); end
    // L and C debounce in the same cycle while in S_B
    press(3, 10);
    vectors += 2;
    if (o_state !== 3'd0) begin miscompares++; $display("FAIL prio_lc_state: got %0d expected 0", o_state); end
    if (o_result !== 8'h00) begin miscompares++; $display("FAIL prio_lc_result: got %h expected 00", o_result); end
  endtask

  task automatic test_reset_mid;
    load_seq(8'h01, 8'h01, 8'h20);
    vectors++;
    if (o_result !== 8'h02) begin miscompares++; $display("FAIL pre_rst_result: got %h expected 02", o_result); end
    sw = 8'h05; press(0, 10);
    sw = 8'h06; press(0, 10);
    vectors++;
    if (o_state !== 3'd2) begin miscompares++; $display("FAIL pre_rst_state: got %0d expected 2", o_state); end
    CPU_RESETN = 1'b0;
    #1;
    vectors += 4;
    if (o_result !== 8'h00) begin miscompares++; $display("FAIL mid_rst_result: got %h expected 00", o_result); end
    if (o_flags !== 5'b00000) begin miscompares++; $display("FAIL mid_rst_flags: got %b expected 00000", o_flags); end
    if (o_state !== 3'd0) begin miscompares++; $display("FAIL mid_rst_state: got %0d expected 0", o_state); end
    if (o_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: got %b expected 0", o_valid); end
    repeat (2) @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    repeat (2) @(negedge CLK100MHZ);
    load_seq(8'h03, 8'h04, 8'h20);
    vectors += 2;
    if (o_result !== 8'h07) begin miscompares++; $display("FAIL post_rst_result: got %h expected 07", o_result); end
    if (o_flags !== 5'b00000) begin miscompares++; $display("FAIL post_rst_flags: got %b expected 00000", o_flags); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    valid_cnt   = 0;
    test_reset();
    test_add();
    test_accumulate();
    test_sub_add();
    test_logic();
    test_shift();
    test_invalid();
    test_bounce();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
